// File: rtl/hilo_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_pkg
//   Shared definitions for the HI/LO multiply/divide engine: the op code
//   values driven by the decoder, the engine state encoding, the
//   accumulate mode applied to a finished product, and small op-decoding
//   helpers used by the top level.
// ---------------------------------------------------------------------------
package hilo_muldiv_pkg;

    // Op codes are carried as a plain 32-bit value so the top can widen its
    // OPW-bit op field once and compare against these without width casts.
    typedef int unsigned opcode_t;

    localparam opcode_t OP_NOP   = 0;
    localparam opcode_t OP_MTHI  = 1;
    localparam opcode_t OP_MTLO  = 2;
    localparam opcode_t OP_MULT  = 3;
    localparam opcode_t OP_MULTU = 4;
    localparam opcode_t OP_DIV   = 5;
    localparam opcode_t OP_DIVU  = 6;
    localparam opcode_t OP_MADD  = 7;
    localparam opcode_t OP_MADDU = 8;
    localparam opcode_t OP_MSUB  = 9;
    localparam opcode_t OP_MSUBU = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // How a registered product is folded into {HI,LO} at commit.
    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } acc_mode_t;

    function automatic logic is_mul_op(input opcode_t code);
        return (code == OP_MULT)  || (code == OP_MULTU) ||
               (code == OP_MADD)  || (code == OP_MADDU) ||
               (code == OP_MSUB)  || (code == OP_MSUBU);
    endfunction

    function automatic logic is_div_op(input opcode_t code);
        return (code == OP_DIV) || (code == OP_DIVU);
    endfunction

    function automatic logic is_signed_mul(input opcode_t code);
        return (code == OP_MULT) || (code == OP_MADD) || (code == OP_MSUB);
    endfunction

    function automatic acc_mode_t acc_mode_of(input opcode_t code);
        case (code)
            OP_MADD, OP_MADDU: return ACC_ADD;
            OP_MSUB, OP_MSUBU: return ACC_SUB;
            default:           return ACC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/hilo_div_core.sv
// ---------------------------------------------------------------------------
// hilo_div_core
//   Unsigned restoring divider, one quotient bit per step. The caller
//   supplies operand magnitudes; sign handling lives in the top level.
//
//   clk, rst   : clock, asynchronous active-low reset
//   start      : load dividend/divisor, clear remainder, arm the counter
//   step       : perform one restoring shift/subtract step
//   dividend   : unsigned dividend magnitude (sampled on start)
//   divisor    : unsigned divisor magnitude (sampled on start, non-zero)
//   quotient   : quotient shift register
//   remainder  : partial remainder register
//   finish     : high while the step now being taken is the last one
// ---------------------------------------------------------------------------
module hilo_div_core #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          finish
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    logic [DW-1:0] rem_q;
    logic [DW-1:0] quo_q;
    logic [DW-1:0] dvs_q;
    logic [CW-1:0] count_q;

    logic [DW:0]   shifted;
    logic [DW-1:0] trial;
    logic          fits;

    // The partial remainder is always below the divisor, so after shifting
    // in the next dividend bit it needs one extra bit; the difference, when
    // it is kept, is again below the divisor and fits back into DW bits.
    assign shifted = {rem_q, quo_q[DW-1]};
    assign trial   = shifted[DW-1:0] - dvs_q;
    assign fits    = (shifted >= {1'b0, dvs_q});

    // Quotient bits enter at the bottom of the dividend register as the
    // dividend bits leave at the top, so one register serves both roles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            count_q <= '0;
        end else if (start) begin
            rem_q   <= '0;
            quo_q   <= dividend;
            dvs_q   <= divisor;
            count_q <= CW'(DW - 1);
        end else if (step) begin
            rem_q <= fits ? trial : shifted[DW-1:0];
            quo_q <= {quo_q[DW-2:0], fits};
            if (count_q != '0) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign finish    = (count_q == '0);

endmodule

// File: rtl/hilo_muldiv.sv
// ---------------------------------------------------------------------------
// hilo_muldiv
//   HI/LO architectural register pair with a multiply/accumulate unit and an
//   iterative restoring divider. Multiplies take one busy cycle, divides
//   DW+1 busy cycles; results reach HI/LO only at the commit edge.
//
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   start     : operation request, only taken when idle and not cancelled
//   op        : operation code (see hilo_muldiv_pkg)
//   src_a     : rs operand / dividend
//   src_b     : rt operand / divisor
//   cancel    : synchronous flush of the requested or in-flight operation
//   busy      : engine occupied
//   done      : one-cycle pulse, HI/LO already hold the committed result
//   hi_rdata  : current HI
//   lo_rdata  : current LO
// ---------------------------------------------------------------------------
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int DW  = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [OPW-1:0] op,
    input  logic [DW-1:0]  src_a,
    input  logic [DW-1:0]  src_b,
    input  logic           cancel,
    output logic           busy,
    output logic           done,
    output logic [DW-1:0]  hi_rdata,
    output logic [DW-1:0]  lo_rdata
);

    state_t          state;
    state_t          next_state;
    opcode_t         op_code;

    logic            do_mthi;
    logic            do_mtlo;
    logic            load_mul;
    logic            load_div;
    logic            load_dz;
    logic            div_step;
    logic            commit_mul;
    logic            commit_div;

    logic [DW-1:0]   hi_q;
    logic [DW-1:0]   lo_q;
    logic            done_q;

    logic            signed_mul;
    logic [2*DW-1:0] ext_a;
    logic [2*DW-1:0] ext_b;
    logic [2*DW-1:0] product;
    logic [2*DW-1:0] prod_q;
    acc_mode_t       acc_mode_q;
    logic [2*DW-1:0] hilo_cur;
    logic [2*DW-1:0] mul_result;

    logic            signed_div;
    logic [DW-1:0]   mag_a;
    logic [DW-1:0]   mag_b;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            div_zero_q;
    logic [DW-1:0]   dz_hi_q;
    logic [DW-1:0]   core_quo;
    logic [DW-1:0]   core_rem;
    logic            core_finish;
    logic [DW-1:0]   div_hi;
    logic [DW-1:0]   div_lo;

    assign op_code = opcode_t'(op);

    // ---------------------------------------------------------------------
    // Multiply datapath. Sign- or zero-extending both operands to 2*DW and
    // keeping the low 2*DW bits of the product gives the correct signed or
    // unsigned result with a single multiplier.
    // ---------------------------------------------------------------------
    assign signed_mul = is_signed_mul(op_code);
    assign ext_a      = signed_mul ? {{DW{src_a[DW-1]}}, src_a} : {{DW{1'b0}}, src_a};
    assign ext_b      = signed_mul ? {{DW{src_b[DW-1]}}, src_b} : {{DW{1'b0}}, src_b};
    assign product    = ext_a * ext_b;

    assign hilo_cur = {hi_q, lo_q};

    always_comb begin
        mul_result = prod_q;
        case (acc_mode_q)
            ACC_ADD: mul_result = hilo_cur + prod_q;
            ACC_SUB: mul_result = hilo_cur - prod_q;
            default: mul_result = prod_q;
        endcase
    end

    // ---------------------------------------------------------------------
    // Divide datapath. The core works on magnitudes; the most negative
    // dividend negates to itself, which is already its correct unsigned
    // magnitude, so min / -1 needs no special handling.
    // ---------------------------------------------------------------------
    assign signed_div = (op_code == OP_DIV);
    assign mag_a      = (signed_div && src_a[DW-1]) ? -src_a : src_a;
    assign mag_b      = (signed_div && src_b[DW-1]) ? -src_b : src_b;

    hilo_div_core #(
        .DW(DW)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (load_div),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (core_quo),
        .remainder (core_rem),
        .finish    (core_finish)
    );

    // A zero divisor bypasses the core entirely; the fix-up cycle then
    // publishes the dividend as HI and all ones as LO.
    always_comb begin
        div_hi = neg_rem_q ? -core_rem : core_rem;
        div_lo = neg_quo_q ? -core_quo : core_quo;
        if (div_zero_q) begin
            div_hi = dz_hi_q;
            div_lo = '1;
        end
    end

    // ---------------------------------------------------------------------
    // Engine state register.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and control decode. Cancel always wins: it blocks a new
    // request in IDLE and suppresses any commit in a busy state.
    // ---------------------------------------------------------------------
    always_comb begin
        next_state = state;
        do_mthi    = 1'b0;
        do_mtlo    = 1'b0;
        load_mul   = 1'b0;
        load_div   = 1'b0;
        load_dz    = 1'b0;
        div_step   = 1'b0;
        commit_mul = 1'b0;
        commit_div = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && !cancel) begin
                    if (op_code == OP_MTHI) begin
                        do_mthi = 1'b1;
                    end else if (op_code == OP_MTLO) begin
                        do_mtlo = 1'b1;
                    end else if (is_mul_op(op_code)) begin
                        load_mul   = 1'b1;
                        next_state = ST_MUL;
                    end else if (is_div_op(op_code)) begin
                        if (src_b == '0) begin
                            load_dz    = 1'b1;
                            next_state = ST_FIX;
                        end else begin
                            load_div   = 1'b1;
                            next_state = ST_DIV;
                        end
                    end
                end
            end
            ST_MUL: begin
                next_state = ST_IDLE;
                commit_mul = !cancel;
            end
            ST_DIV: begin
                if (cancel) begin
                    next_state = ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (core_finish) begin
                        next_state = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                next_state = ST_IDLE;
                commit_div = !cancel;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Operand-side registers captured on acceptance: the registered product
    // with its accumulate mode, and the divide sign/zero bookkeeping.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q     <= '0;
            acc_mode_q <= ACC_NONE;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            dz_hi_q    <= '0;
        end else begin
            if (load_mul) begin
                prod_q     <= product;
                acc_mode_q <= acc_mode_of(op_code);
            end
            if (load_div) begin
                neg_quo_q  <= signed_div && (src_a[DW-1] ^ src_b[DW-1]);
                neg_rem_q  <= signed_div && src_a[DW-1];
                div_zero_q <= 1'b0;
            end
            if (load_dz) begin
                neg_quo_q  <= 1'b0;
                neg_rem_q  <= 1'b0;
                div_zero_q <= 1'b1;
                dz_hi_q    <= src_a;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Architectural HI/LO and the done pulse. Only these registers drive the
    // read ports, so in-progress arithmetic is never visible.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= do_mthi | do_mtlo | commit_mul | commit_div;
            if (do_mthi) begin
                hi_q <= src_a;
            end else if (do_mtlo) begin
                lo_q <= src_a;
            end else if (commit_mul) begin
                hi_q <= mul_result[2*DW-1:DW];
                lo_q <= mul_result[DW-1:0];
            end else if (commit_div) begin
                hi_q <= div_hi;
                lo_q <= div_lo;
            end
        end
    end

    assign busy     = (state != ST_IDLE);
    assign done     = done_q;
    assign hi_rdata = hi_q;
    assign lo_rdata = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv
//   Self-checking bench for hilo_muldiv. A cycle-level reference model
//   tracks HI/LO, remaining busy cycles and the done pulse from the
//   architectural rules; a compare process checks every cycle, and directed
//   tests pin hand-computed results and latencies.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv;

    localparam int DW  = 32;
    localparam int OPW = 4;

    localparam logic [3:0] T_NOP   = 4'd0;
    localparam logic [3:0] T_MTHI  = 4'd1;
    localparam logic [3:0] T_MTLO  = 4'd2;
    localparam logic [3:0] T_MULT  = 4'd3;
    localparam logic [3:0] T_MULTU = 4'd4;
    localparam logic [3:0] T_DIV   = 4'd5;
    localparam logic [3:0] T_DIVU  = 4'd6;
    localparam logic [3:0] T_MADD  = 4'd7;
    localparam logic [3:0] T_MADDU = 4'd8;
    localparam logic [3:0] T_MSUB  = 4'd9;
    localparam logic [3:0] T_MSUBU = 4'd10;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          start  = 1'b0;
    logic [3:0]    op     = 4'd0;
    logic [31:0]   src_a  = 32'd0;
    logic [31:0]   src_b  = 32'd0;
    logic          cancel = 1'b0;
    logic          busy;
    logic          done;
    logic [31:0]   hi_rdata;
    logic [31:0]   lo_rdata;

    hilo_muldiv #(
        .DW  (DW),
        .OPW (OPW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .hi_rdata (hi_rdata),
        .lo_rdata (lo_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: HI/LO values, pending result and busy cycles left.
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic [31:0] p_hi   = 32'd0;
    logic [31:0] p_lo   = 32'd0;
    int          m_left = 0;
    bit          m_done = 1'b0;

    task automatic model_accept();
        int          ia, ib;
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, full, res, tmp;
        ia = src_a;
        ib = src_b;
        sa = ia;
        sb = ib;
        ua = {32'd0, src_a};
        ub = {32'd0, src_b};
        full = 64'd0;
        if (op == T_MULT || op == T_MADD || op == T_MSUB) begin
            full = 64'(sa * sb);
        end else begin
            full = ua * ub;
        end
        case (op)
            T_MTHI: begin
                m_hi   = src_a;
                m_done = 1'b1;
            end
            T_MTLO: begin
                m_lo   = src_a;
                m_done = 1'b1;
            end
            T_MULT, T_MULTU, T_MADD, T_MADDU, T_MSUB, T_MSUBU: begin
                res = full;
                if (op == T_MADD || op == T_MADDU) res = {m_hi, m_lo} + full;
                if (op == T_MSUB || op == T_MSUBU) res = {m_hi, m_lo} - full;
                p_hi   = res[63:32];
                p_lo   = res[31:0];
                m_left = 1;
            end
            T_DIV, T_DIVU: begin
                if (src_b == 32'd0) begin
                    p_hi   = src_a;
                    p_lo   = 32'hFFFF_FFFF;
                    m_left = 1;
                end else if (op == T_DIV) begin
                    sq   = sa / sb;
                    sr   = sa % sb;
                    tmp  = 64'(sq);
                    p_lo = tmp[31:0];
                    tmp  = 64'(sr);
                    p_hi = tmp[31:0];
                    m_left = DW + 1;
                end else begin
                    p_lo   = src_a / src_b;
                    p_hi   = src_a % src_b;
                    m_left = DW + 1;
                end
            end
            default: begin
            end
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (cancel) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi   = p_hi;
                        m_lo   = p_lo;
                        m_done = 1'b1;
                    end
                end
            end else if (start && !cancel) begin
                model_accept();
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst) begin
            check_output("model_hi", hi_rdata, m_hi);
            check_output("model_lo", lo_rdata, m_lo);
            check_output("model_busy", 32'(busy), 32'(m_left > 0));
            check_output("model_done", 32'(done), 32'(m_done));
        end
    end

    // Issue one request and observe it. cancel_at: cycle to assert cancel
    // (0 = together with start, -1 = never); restart_at: cycle to raise a
    // second MULT request while busy (-1 = never). Cycle c is sampled at the
    // c-th falling edge after the request is driven.
    task automatic apply_stimulus(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                                  input int cancel_at, input int restart_at,
                                  output int busy_cnt, output int done_at, output int busy_after_cancel);
        @(negedge clk);
        start  = 1'b1;
        op     = code;
        src_a  = a;
        src_b  = b;
        cancel = (cancel_at == 0);
        busy_cnt          = 0;
        done_at           = -1;
        busy_after_cancel = -1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (c == restart_at) begin
                op    = T_MULT;
                src_a = 32'd2;
                src_b = 32'd3;
            end
            cancel = (c == cancel_at);
            if (busy) busy_cnt++;
            if (done && done_at < 0) done_at = c;
            if (cancel_at >= 0 && c == cancel_at + 1) busy_after_cancel = int'(busy);
            if (done_at > 0) break;
            if (c >= 4 && !busy) break;
        end
        start  = 1'b0;
        cancel = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int bc, da, bac, done_seen;

        #1;
        check_output("reset_hi", hi_rdata, 32'd0);
        check_output("reset_lo", lo_rdata, 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        cmp_en = 1'b1;

        // MULT -2 * 3
        apply_stimulus(T_MULT, 32'hFFFF_FFFE, 32'd3, -1, -1, bc, da, bac);
        check_output("t1_hi", hi_rdata, 32'hFFFF_FFFF);
        check_output("t1_lo", lo_rdata, 32'hFFFF_FFFA);
        check_output("t1_busy_cycles", 32'(bc), 32'd1);
        check_output("t1_done_cycle", 32'(da), 32'd2);

        // MTHI / MTLO then MADDU carrying into HI
        apply_stimulus(T_MTHI, 32'd0, 32'd0, -1, -1, bc, da, bac);
        check_output("t2_mthi_busy", 32'(bc), 32'd0);
        check_output("t2_mthi_done", 32'(da), 32'd1);
        apply_stimulus(T_MTLO, 32'hFFFF_FFFF, 32'd0, -1, -1, bc, da, bac);
        check_output("t2_mtlo_lo", lo_rdata, 32'hFFFF_FFFF);
        apply_stimulus(T_MADDU, 32'd1, 32'd1, -1, -1, bc, da, bac);
        check_output("t2_hi", hi_rdata, 32'h0000_0001);
        check_output("t2_lo", lo_rdata, 32'h0000_0000);

        // MSUB {1,0} - (-2*3) = {1,6}; then model-checked MADD/MSUBU
        apply_stimulus(T_MSUB, 32'hFFFF_FFFE, 32'd3, -1, -1, bc, da, bac);
        check_output("msub_hi", hi_rdata, 32'h0000_0001);
        check_output("msub_lo", lo_rdata, 32'h0000_0006);
        apply_stimulus(T_MADD, 32'h7FFF_FFFF, 32'd2, -1, -1, bc, da, bac);
        apply_stimulus(T_MSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, bc, da, bac);

        // DIV -7 / 2 with an ignored MULT request while busy
        apply_stimulus(T_DIV, 32'hFFFF_FFF9, 32'd2, -1, 5, bc, da, bac);
        check_output("t3_lo", lo_rdata, 32'hFFFF_FFFD);
        check_output("t3_hi", hi_rdata, 32'hFFFF_FFFF);
        check_output("t3_busy_cycles", 32'(bc), 32'd33);
        check_output("t3_done_cycle", 32'(da), 32'd34);

        // Signed overflow, negative divisor, divide by zero
        apply_stimulus(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, bc, da, bac);
        check_output("t4_ovf_lo", lo_rdata, 32'h8000_0000);
        check_output("t4_ovf_hi", hi_rdata, 32'h0000_0000);
        apply_stimulus(T_DIV, 32'd100, 32'hFFFF_FFF9, -1, -1, bc, da, bac);
        check_output("div_negb_lo", lo_rdata, 32'hFFFF_FFF2);
        check_output("div_negb_hi", hi_rdata, 32'h0000_0002);
        apply_stimulus(T_DIVU, 32'd5, 32'd0, -1, -1, bc, da, bac);
        check_output("t4_dz_hi", hi_rdata, 32'h0000_0005);
        check_output("t4_dz_lo", lo_rdata, 32'hFFFF_FFFF);
        check_output("t4_dz_busy", 32'(bc), 32'd1);

        // DIVU cancelled in busy cycle 10, then a fresh MULTU
        apply_stimulus(T_DIVU, 32'd100, 32'd7, 10, -1, bc, da, bac);
        check_output("t5_hi_kept", hi_rdata, 32'h0000_0005);
        check_output("t5_lo_kept", lo_rdata, 32'hFFFF_FFFF);
        check_output("t5_no_done", 32'(da), 32'hFFFF_FFFF);
        check_output("t5_busy_after", 32'(bac), 32'd0);
        repeat (3) @(negedge clk);
        apply_stimulus(T_MULTU, 32'd6, 32'd7, -1, -1, bc, da, bac);
        check_output("t5_lo", lo_rdata, 32'd42);
        check_output("t5_hi", hi_rdata, 32'd0);

        // Cancel on the commit cycle, cancel with start, and an undefined op
        apply_stimulus(T_MULT, 32'd9, 32'd9, 1, -1, bc, da, bac);
        check_output("cancel_commit_lo", lo_rdata, 32'd42);
        check_output("cancel_commit_done", 32'(da), 32'hFFFF_FFFF);
        apply_stimulus(T_MTLO, 32'h1234_5678, 32'd0, 0, -1, bc, da, bac);
        check_output("cancel_start_lo", lo_rdata, 32'd42);
        apply_stimulus(4'd13, 32'hDEAD_BEEF, 32'd1, -1, -1, bc, da, bac);
        check_output("undef_op_done", 32'(da), 32'hFFFF_FFFF);
        check_output("undef_op_lo", lo_rdata, 32'd42);

        // Asynchronous reset in the middle of a divide, away from the clock edge
        apply_stimulus(T_MTHI, 32'hCAFE_0001, 32'd0, -1, -1, bc, da, bac);
        @(negedge clk);
        start = 1'b1;
        op    = T_DIV;
        src_a = 32'd100;
        src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_output("t6_busy_before", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_output("t6_hi", hi_rdata, 32'd0);
        check_output("t6_lo", lo_rdata, 32'd0);
        check_output("t6_busy", 32'(busy), 32'd0);
        check_output("t6_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check_output("t6_no_done", 32'(done_seen), 32'd0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
